// File: rtl/mux_rr_pkg.sv
// Shared definitions for the round-robin multiplexer and its arbiter.
package mux_rr_pkg;

  localparam int STAT_W = 16;

  typedef logic [STAT_W-1:0] stat_t;

  // Ceiling log2, floored at 1 so a channel index is never zero-width.
  function automatic int clog2_f(input int unsigned v);
    int r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = int'(i) + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_nbit_if.sv
// Producer/consumer bundle for mux_rr_nbit: M request channels in, one tagged channel out.
interface mux_rr_nbit_if
  import mux_rr_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 4
);
  localparam int SEL_W = clog2_f(M);

  logic [M*N-1:0]   in_data;
  logic [M-1:0]     in_valid;
  logic [M-1:0]     in_ready;
  logic [N-1:0]     out_data;
  logic [SEL_W-1:0] out_sel;
  logic             out_valid;
  logic             out_ready;

  // The multiplexer side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  // The producers/consumer side.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting one past last_grant,
// wrapping around; the first set bit wins. All grant outputs are gated by en.
module rr_arbiter
  import mux_rr_pkg::*;
#(
  parameter int M = 4,
  localparam int SEL_W = clog2_f(M)
) (
  input  logic [M-1:0]     req,
  input  logic [SEL_W-1:0] last_grant,
  input  logic             en,
  output logic [M-1:0]     gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [SEL_W-1:0] w_idx;
  logic             w_found;

  // Rotating find-first over the request vector.
  always_comb begin
    w_idx      = '0;
    w_found    = 1'b0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    gnt_onehot = '0;
    for (int unsigned k = 1; k <= M; k++) begin
      w_idx = SEL_W'((32'(last_grant) + k) % 32'(M));
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        gnt_idx = w_idx;
      end
    end
    gnt_any    = w_found & en;
    gnt_onehot = gnt_any ? (M'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/mux_rr_nbit.sv
// Registered M-input, N-bit round-robin arbitrating multiplexer with valid/ready
// on every channel. Optional per-channel grant counters under MUX_RR_STATS_EN.
module mux_rr_nbit
  import mux_rr_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_rr_nbit_if.slave   bus
`ifdef MUX_RR_STATS_EN
  ,
  input  logic              clr_stats,
  output logic [M*STAT_W-1:0] grant_cnt
`endif
);

  localparam int SEL_W = clog2_f(M);

  logic [N-1:0]     r_data;
  logic [SEL_W-1:0] r_sel;
  logic             r_valid;
  logic [SEL_W-1:0] r_last_grant;

  logic             w_load;
  logic [M-1:0]     w_gnt_onehot;
  logic [SEL_W-1:0] w_gnt_idx;
  logic             w_gnt_any;
  logic [N-1:0]     w_data_sel;

  // Output register may refill in the same cycle it drains.
  assign w_load = ~r_valid | bus.out_ready;

  rr_arbiter #(.M(M)) u_arb (
    .req        (bus.in_valid),
    .last_grant (r_last_grant),
    .en         (w_load),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx),
    .gnt_any    (w_gnt_any)
  );

  // Grant is already qualified by load, so it doubles as the accept vector.
  assign bus.in_ready  = w_gnt_onehot;
  assign bus.out_data  = r_data;
  assign bus.out_sel   = r_sel;
  assign bus.out_valid = r_valid;

  // One-hot AND-OR select of the granted channel's data.
  always_comb begin
    w_data_sel = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (w_gnt_onehot[i]) w_data_sel = w_data_sel | bus.in_data[i*N +: N];
    end
  end

  // Output register and round-robin pointer; pointer moves only on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_sel        <= '0;
      r_valid      <= 1'b0;
      r_last_grant <= SEL_W'(M - 1);
    end else if (w_load) begin
      if (w_gnt_any) begin
        r_data       <= w_data_sel;
        r_sel        <= w_gnt_idx;
        r_valid      <= 1'b1;
        r_last_grant <= w_gnt_idx;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_RR_STATS_EN
  stat_t r_cnt [M];

  // Saturating per-channel transfer counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < M; i++) r_cnt[i] <= '0;
    end else if (clr_stats) begin
      for (int unsigned i = 0; i < M; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < M; i++) begin
        if (w_gnt_onehot[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  // Flatten counters onto the output bus, channel i at [i*STAT_W +: STAT_W].
  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < M; i++) grant_cnt[i*STAT_W +: STAT_W] = r_cnt[i];
  end
`endif

endmodule

// File: tb/tb_mux_rr_nbit.sv
// Directed bench for mux_rr_nbit (N=4, M=4) with a reference arbitration model
// and an expected-output scoreboard queue.
module tb_mux_rr_nbit;
  import mux_rr_pkg::*;

  typedef struct packed {
    logic [3:0] d;
    logic [1:0] s;
  } exp_t;

  logic clk;
  logic rst_n;
`ifdef MUX_RR_STATS_EN
  logic        clr_stats;
  logic [63:0] grant_cnt;
`endif

  mux_rr_nbit_if #(.N(4), .M(4)) bus ();

  mux_rr_nbit #(.N(4), .M(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef MUX_RR_STATS_EN
    ,
    .clr_stats (clr_stats),
    .grant_cnt (grant_cnt)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   m_ov;
  int   m_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // One clock of stimulus: check at negedge against the model, then advance the model.
  task automatic step();
    logic       ld;
    bit         found;
    int         g;
    logic [3:0] exp_rdy;
    exp_t       e;
    @(negedge clk);
    ld    = !m_ov || bus.out_ready;
    found = 1'b0;
    g     = 0;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_last + k) % 4;
      if (!found && bus.in_valid[c]) begin
        found = 1'b1;
        g     = c;
      end
    end
    exp_rdy = (ld && found) ? 4'(1 << g) : 4'b0000;
    checks++;
    assert (bus.in_ready === exp_rdy) else begin
      errors++;
      $error("FAIL in_ready: got %b, expected %b", bus.in_ready, exp_rdy);
    end
    checks++;
    assert (bus.out_valid === m_ov) else begin
      errors++;
      $error("FAIL out_valid: got %b, expected %b", bus.out_valid, m_ov);
    end
    if (m_ov) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard: got out_valid with empty queue, expected a pending word");
      end else begin
        e = sb[0];
        checks++;
        assert (bus.out_data === e.d) else begin
          errors++;
          $error("FAIL out_data: got %h, expected %h", bus.out_data, e.d);
        end
        checks++;
        assert (bus.out_sel === e.s) else begin
          errors++;
          $error("FAIL out_sel: got %0d, expected %0d", bus.out_sel, e.s);
        end
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
    if (ld && found) begin
      e.d = bus.in_data[g*4 +: 4];
      e.s = 2'(g);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (ld) begin
      if (found) begin
        m_ov   = 1'b1;
        m_last = g;
      end else begin
        m_ov = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
`ifdef MUX_RR_STATS_EN
    clr_stats = 1'b0;
`endif
    m_ov   = 1'b0;
    m_last = 3;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert (bus.out_valid === 1'b0) else begin
      errors++; $error("FAIL reset out_valid: got %b, expected 0", bus.out_valid);
    end
    checks++;
    assert (bus.out_data === 4'h0) else begin
      errors++; $error("FAIL reset out_data: got %h, expected 0", bus.out_data);
    end
    checks++;
    assert (bus.out_sel === 2'd0) else begin
      errors++; $error("FAIL reset out_sel: got %0d, expected 0", bus.out_sel);
    end
    rst_n = 1'b1;

    // All four channels requesting: 0,1,2,3,0 at full rate.
    bus.in_data  = {4'h4, 4'h3, 4'h2, 4'h1};
    bus.in_valid = 4'b1111;
    repeat (5) step();

    // Single requester on channel 2.
    bus.in_data  = {4'h0, 4'hA, 4'h0, 4'h0};
    bus.in_valid = 4'b0100;
    repeat (5) step();

    // Park the pointer on channel 0.
    bus.in_data  = {4'h0, 4'h0, 4'h0, 4'h5};
    bus.in_valid = 4'b0001;
    step();

    // Channels 1 and 3 with a three-cycle backpressure stall after the first capture.
    bus.in_data  = {4'h9, 4'h0, 4'h7, 4'h0};
    bus.in_valid = 4'b1010;
    step();
    bus.out_ready = 1'b0;
    repeat (3) step();
    bus.out_ready = 1'b1;
    repeat (2) step();

    // Pointer at 3, channels 0 and 3 requesting: wrap to 0, then 3.
    bus.in_data  = {4'h8, 4'h0, 4'h0, 4'h6};
    bus.in_valid = 4'b1000;
    step();
    bus.in_valid = 4'b1001;
    repeat (2) step();

    // Drain with no requests.
    bus.in_valid = 4'b0000;
    repeat (2) step();
    checks++;
    assert (sb.size() === 0) else begin
      errors++; $error("FAIL drain queue: got %0d pending, expected 0", sb.size());
    end

    // Reset mid-stream while the output holds a word.
    bus.in_data  = {4'h4, 4'h3, 4'h2, 4'h1};
    bus.in_valid = 4'b1111;
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    checks++;
    assert (bus.out_valid === 1'b0) else begin
      errors++; $error("FAIL async reset out_valid: got %b, expected 0", bus.out_valid);
    end
    checks++;
    assert (bus.out_sel === 2'd0) else begin
      errors++; $error("FAIL async reset out_sel: got %0d, expected 0", bus.out_sel);
    end
    sb.delete();
    m_ov   = 1'b0;
    m_last = 3;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step();

`ifdef MUX_RR_STATS_EN
    // Saturation of channel 0's counter, then clear coinciding with a transfer.
    bus.in_data  = {4'h0, 4'h0, 4'h0, 4'hC};
    bus.in_valid = 4'b0001;
    repeat (70000) step();
    checks++;
    assert (grant_cnt[15:0] === 16'hFFFF) else begin
      errors++; $error("FAIL stats saturate: got %h, expected ffff", grant_cnt[15:0]);
    end
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    checks++;
    assert (grant_cnt[15:0] === 16'h0000) else begin
      errors++; $error("FAIL stats clear: got %h, expected 0000", grant_cnt[15:0]);
    end
`endif

    bus.in_valid = 4'b0000;
    repeat (2) step();
    checks++;
    assert (sb.size() === 0) else begin
      errors++; $error("FAIL final queue: got %0d pending, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
